// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags: commit write,
// issue-side tag allocation, rollback, and two combinational source read ports.
module reg_file_rename #(
  parameter int REG_NUM   = 32,
  parameter int REG_POS_W = 5,
  parameter int DATA_W    = 32,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 reg_write,
  input  logic [REG_POS_W-1:0] reg_rd,
  input  logic [DATA_W-1:0]    reg_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic                 issue,
  input  logic [REG_POS_W-1:0] issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic [REG_POS_W-1:0] rs1,
  input  logic [REG_POS_W-1:0] rs2,
  output logic [DATA_W-1:0]    rs1_val,
  output logic                 rs1_busy,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  output logic [DATA_W-1:0]    rs2_val,
  output logic                 rs2_busy,
  output logic [ROB_POS_W-1:0] rs2_rob_pos
);
  localparam int NUM_PORTS = 2;

  logic [REG_NUM-1:0][DATA_W-1:0]    val;
  logic [REG_NUM-1:0]                busy;
  logic [REG_NUM-1:0][ROB_POS_W-1:0] tag;

  logic commit_ok, issue_ok;
  assign commit_ok = reg_write && (reg_rd != '0);
  assign issue_ok  = issue && (issue_rd != '0) && !rollback;

  always_ff @(posedge clk) begin
    if (rst) begin
      val  <= '0;
      busy <= '0;
      tag  <= '0;
    end else if (rdy) begin
      if (commit_ok) begin
        val[reg_rd] <= reg_val;
        // Stale commits (tag already reassigned) write the value but keep busy.
        if (tag[reg_rd] == commit_rob_pos && !(issue_ok && issue_rd == reg_rd))
          busy[reg_rd] <= 1'b0;
      end
      if (rollback)
        busy <= '0;
      if (issue_ok) begin
        busy[issue_rd] <= 1'b1;
        tag[issue_rd]  <= issue_rob_pos;
      end
    end
  end

  logic [NUM_PORTS-1:0][REG_POS_W-1:0] rs_idx;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    rs_val;
  logic [NUM_PORTS-1:0]                rs_busy;
  logic [NUM_PORTS-1:0][ROB_POS_W-1:0] rs_pos;

  assign rs_idx = {rs2, rs1};

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_rd
      reg_file_rename_rd_port #(
        .REG_POS_W(REG_POS_W), .DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W)
      ) u_rd (
        .rs             (rs_idx[p]),
        .ent_val        (val[rs_idx[p]]),
        .ent_busy       (busy[rs_idx[p]]),
        .ent_tag        (tag[rs_idx[p]]),
        .reg_write      (reg_write),
        .reg_rd         (reg_rd),
        .reg_val        (reg_val),
        .commit_rob_pos (commit_rob_pos),
        .out_val        (rs_val[p]),
        .out_busy       (rs_busy[p]),
        .out_pos        (rs_pos[p])
      );
    end
  endgenerate

  assign rs1_val     = rs_val[0];
  assign rs1_busy    = rs_busy[0];
  assign rs1_rob_pos = rs_pos[0];
  assign rs2_val     = rs_val[1];
  assign rs2_busy    = rs_busy[1];
  assign rs2_rob_pos = rs_pos[1];
endmodule

// One source read port: committed state, or the value retiring this cycle.
module reg_file_rename_rd_port #(
  parameter int REG_POS_W = 5,
  parameter int DATA_W    = 32,
  parameter int ROB_POS_W = 4
) (
  input  logic [REG_POS_W-1:0] rs,
  input  logic [DATA_W-1:0]    ent_val,
  input  logic                 ent_busy,
  input  logic [ROB_POS_W-1:0] ent_tag,
  input  logic                 reg_write,
  input  logic [REG_POS_W-1:0] reg_rd,
  input  logic [DATA_W-1:0]    reg_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  output logic [DATA_W-1:0]    out_val,
  output logic                 out_busy,
  output logic [ROB_POS_W-1:0] out_pos
);
  logic bypass;
  assign bypass = reg_write && (reg_rd == rs) && ent_busy && (ent_tag == commit_rob_pos);

  always_comb begin
    out_val  = ent_val;
    out_busy = ent_busy;
    out_pos  = ent_tag;
    if (rs == '0) begin
      out_val  = '0;
      out_busy = 1'b0;
      out_pos  = '0;
    end else if (bypass) begin
      out_val  = reg_val;
      out_busy = 1'b0;
    end
  end
endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename with an expectation queue checked at negedge.
module tb_reg_file_rename;
  logic        clk = 1'b0;
  logic        rst, rdy, rollback, reg_write, issue;
  logic [4:0]  reg_rd, issue_rd, rs1, rs2;
  logic [31:0] reg_val;
  logic [3:0]  commit_rob_pos, issue_rob_pos;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_rob_pos, rs2_rob_pos;

  int n_asrt = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    bit          port;
    logic [31:0] v;
    logic        b;
    logic [3:0]  p;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  reg_file_rename dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
    .commit_rob_pos(commit_rob_pos), .issue(issue), .issue_rd(issue_rd),
    .issue_rob_pos(issue_rob_pos), .rs1(rs1), .rs2(rs2),
    .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_rob_pos(rs1_rob_pos),
    .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_rob_pos(rs2_rob_pos)
  );

  task automatic idle();
    rdy = 1'b1; rollback = 1'b0; reg_write = 1'b0; issue = 1'b0;
    reg_rd = '0; reg_val = '0; commit_rob_pos = '0; issue_rd = '0; issue_rob_pos = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [3:0] pos);
    issue = 1'b1; issue_rd = rd; issue_rob_pos = pos;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [3:0] pos, input logic [31:0] v);
    reg_write = 1'b1; reg_rd = rd; commit_rob_pos = pos; reg_val = v;
  endtask

  task automatic expect_rd(input string name, input bit port, input logic [31:0] v,
                           input logic b, input logic [3:0] p);
    exp_t e;
    e.name = name; e.port = port; e.v = v; e.b = b; e.p = p;
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    logic [31:0] ov;
    logic        ob;
    logic [3:0]  op;
    @(negedge clk);
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ov = e.port ? rs2_val     : rs1_val;
      ob = e.port ? rs2_busy    : rs1_busy;
      op = e.port ? rs2_rob_pos : rs1_rob_pos;
      n_asrt++;
      assert (ov === e.v) else begin
        n_fail++; $error("FAIL %s val: observed %h expected %h", e.name, ov, e.v);
      end
      n_asrt++;
      assert (ob === e.b) else begin
        n_fail++; $error("FAIL %s busy: observed %b expected %b", e.name, ob, e.b);
      end
      n_asrt++;
      assert (op === e.p) else begin
        n_fail++; $error("FAIL %s rob_pos: observed %0d expected %0d", e.name, op, e.p);
      end
    end
  endtask

  initial begin
    idle();
    rst = 1'b1; rs1 = 5'd5; rs2 = 5'd0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    expect_rd("reset_rs1", 0, 32'h0, 1'b0, 4'd0);
    expect_rd("reset_rs2", 1, 32'h0, 1'b0, 4'd0);
    chk();

    // issue then commit with bypass
    @(posedge clk); #1;
    do_issue(5'd3, 4'd7); tick();
    rs1 = 5'd3;
    expect_rd("x3_pending", 0, 32'h0, 1'b1, 4'd7);
    chk();
    do_commit(5'd3, 4'd7, 32'hDEADBEEF);
    expect_rd("x3_bypass", 0, 32'hDEADBEEF, 1'b0, 4'd7);
    chk();
    tick();
    expect_rd("x3_committed", 0, 32'hDEADBEEF, 1'b0, 4'd7);
    chk();

    // stale commit: value written, busy kept by the newer tag
    @(posedge clk); #1;
    do_issue(5'd4, 4'd2); tick();
    do_issue(5'd4, 4'd5); tick();
    rs1 = 5'd4;
    do_commit(5'd4, 4'd2, 32'h11);
    expect_rd("x4_stale_same_cycle", 0, 32'h0, 1'b1, 4'd5);
    chk();
    tick();
    expect_rd("x4_stale_after", 0, 32'h11, 1'b1, 4'd5);
    chk();

    // same-cycle commit and issue to one register
    @(posedge clk); #1;
    do_issue(5'd6, 4'd1); tick();
    rs1 = 5'd6;
    do_commit(5'd6, 4'd1, 32'h22);
    do_issue(5'd6, 4'd9);
    expect_rd("x6_read_old_producer", 0, 32'h22, 1'b0, 4'd1);
    chk();
    tick();
    expect_rd("x6_issue_wins", 0, 32'h22, 1'b1, 4'd9);
    chk();

    // rollback clears busy, drops the issue, keeps the commit value
    @(posedge clk); #1;
    do_issue(5'd1, 4'd1); tick();
    do_issue(5'd2, 4'd2); tick();
    do_issue(5'd3, 4'd3); tick();
    rs1 = 5'd1; rs2 = 5'd3;
    expect_rd("x1_busy", 0, 32'h0, 1'b1, 4'd1);
    expect_rd("x3_busy", 1, 32'hDEADBEEF, 1'b1, 4'd3);
    chk();
    rollback = 1'b1;
    do_issue(5'd8, 4'd4);
    do_commit(5'd9, 4'd0, 32'h77);
    tick();
    rs1 = 5'd8; rs2 = 5'd3;
    expect_rd("x8_after_rollback", 0, 32'h0, 1'b0, 4'd0);
    expect_rd("x3_after_rollback", 1, 32'hDEADBEEF, 1'b0, 4'd3);
    chk();
    rs1 = 5'd2; rs2 = 5'd4;
    expect_rd("x2_after_rollback", 0, 32'h0, 1'b0, 4'd2);
    expect_rd("x4_after_rollback", 1, 32'h11, 1'b0, 4'd5);
    chk();
    rs1 = 5'd9;
    expect_rd("x9_commit_during_rollback", 0, 32'h77, 1'b0, 4'd0);
    chk();

    // x0 is immutable
    @(posedge clk); #1;
    do_commit(5'd0, 4'd6, 32'h55);
    do_issue(5'd0, 4'd6);
    rs1 = 5'd0;
    expect_rd("x0_same_cycle", 0, 32'h0, 1'b0, 4'd0);
    chk();
    tick();
    expect_rd("x0_after", 0, 32'h0, 1'b0, 4'd0);
    chk();

    // rdy=0 freezes state
    @(posedge clk); #1;
    rdy = 1'b0;
    do_issue(5'd2, 4'd7);
    do_commit(5'd5, 4'd0, 32'h99);
    tick();
    rs1 = 5'd2; rs2 = 5'd5;
    expect_rd("x2_frozen", 0, 32'h0, 1'b0, 4'd2);
    expect_rd("x5_frozen", 1, 32'h0, 1'b0, 4'd0);
    chk();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
